// File: rtl/sram_arb_pkg.sv
// Shared encodings for the two-port SRAM arbiter: FSM states, HSIZE codes
// and requester port indices.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10
   } arb_state_e;

   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HALF  = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;

   localparam logic PORT_AHB = 1'b0;
   localparam logic PORT_SII = 1'b1;

endpackage

// File: rtl/sram_rr_picker.sv
// Two-way round-robin selector: a lone pending port wins outright, and when
// both are pending the port that was not served last wins.
module sram_rr_picker
   import sram_arb_pkg::*;
(
   input  logic [1:0] pend,
   input  logic       last,
   output logic       winner,
   output logic       valid
);

   // Pick the winner from the pending flags and the last-served port
   always_comb begin
      valid  = |pend;
      winner = PORT_AHB;
      unique case (pend)
         2'b10:   winner = PORT_SII;
         2'b11:   winner = ~last;
         default: winner = PORT_AHB;
      endcase
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM controller port between the AHB slave (port 0) and the SII
// master (port 1). Round-robin arbitration, ack routing, busy flags and a
// watchdog that forces an error ack when the controller never answers.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int AHB_DWIDTH  = 32,
   parameter int ADDR_WIDTH  = 20,
   parameter int ACK_TIMEOUT = 255,
   parameter int TO_WIDTH    = 8
) (
   input  logic                  HCLK,
   input  logic                  HRESETN,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  write0,
   input  logic                  write1,
   input  logic [2:0]            size0,
   input  logic [2:0]            size1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [AHB_DWIDTH-1:0] wdata0,
   input  logic [AHB_DWIDTH-1:0] wdata1,
   output logic                  ack0,
   output logic                  ack1,
   output logic                  err0,
   output logic                  err1,
   output logic                  busy0,
   output logic                  busy1,
   output logic [AHB_DWIDTH-1:0] rdata,
   output logic                  sram_req,
   output logic                  sram_write,
   output logic [2:0]            sram_size,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [AHB_DWIDTH-1:0] sram_wdata,
   input  logic                  sram_ack,
   input  logic [AHB_DWIDTH-1:0] sram_rdata
);

   arb_state_e          state;
   logic                pend0;
   logic                pend1;
   logic                grant;
   logic                last;
   logic [TO_WIDTH-1:0] cnt;

   logic                pick_winner;
   logic                pick_valid;
   logic                active;
   logic                timeout;
   logic                ack_any;
   logic                err_any;
   logic                sel;

   sram_rr_picker u_picker (
      .pend   ({pend1, pend0}),
      .last   (last),
      .winner (pick_winner),
      .valid  (pick_valid)
   );

   // Completion decode: real ack in ISSUE/WAIT, or watchdog expiry in WAIT
   always_comb begin
      active  = (state != ST_IDLE);
      timeout = (state == ST_WAIT) && (cnt == TO_WIDTH'(ACK_TIMEOUT - 1));
      ack_any = ((state == ST_ISSUE) && sram_ack) ||
                ((state == ST_WAIT) && (sram_ack || timeout));
      err_any = timeout && !sram_ack;
      ack0    = ack_any && (grant == PORT_AHB);
      ack1    = ack_any && (grant == PORT_SII);
      err0    = err_any && (grant == PORT_AHB);
      err1    = err_any && (grant == PORT_SII);
      busy0   = active && (grant == PORT_SII);
      busy1   = active && (grant == PORT_AHB);
   end

   // Command mux: granted port while a transfer is open, port 0 when idle
   always_comb begin
      sel        = active && (grant == PORT_SII);
      sram_req   = (state == ST_ISSUE);
      sram_write = active && (sel ? write1 : write0);
      sram_size  = sel ? size1  : size0;
      sram_addr  = sel ? addr1  : addr0;
      sram_wdata = sel ? wdata1 : wdata0;
      rdata      = sram_rdata;
   end

   // Pending flags and arbitration FSM; a new req beats the clearing ack
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         state <= ST_IDLE;
         pend0 <= 1'b0;
         pend1 <= 1'b0;
         grant <= PORT_AHB;
         last  <= PORT_SII;
         cnt   <= '0;
      end else begin
         pend0 <= req0 | (pend0 & ~ack0);
         pend1 <= req1 | (pend1 & ~ack1);
         unique case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  grant <= pick_winner;
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt <= '0;
               if (sram_ack) begin
                  last  <= grant;
                  state <= ST_IDLE;
               end else begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               cnt <= cnt + TO_WIDTH'(1);
               if (ack_any) begin
                  last  <= grant;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_sram_port_arbiter;
   import sram_arb_pkg::*;

   logic        HCLK;
   logic        HRESETN;
   logic        req0, req1, write0, write1;
   logic [2:0]  size0, size1;
   logic [19:0] addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        ack0, ack1, err0, err1, busy0, busy1;
   logic [31:0] rdata;
   logic        sram_req, sram_write;
   logic [2:0]  sram_size;
   logic [19:0] sram_addr;
   logic [31:0] sram_wdata;
   logic        sram_ack;
   logic [31:0] sram_rdata;

   int n_checks = 0;
   int n_pass   = 0;

   sram_port_arbiter #(
      .AHB_DWIDTH  (32),
      .ADDR_WIDTH  (20),
      .ACK_TIMEOUT (4),
      .TO_WIDTH    (8)
   ) dut (
      .HCLK       (HCLK),
      .HRESETN    (HRESETN),
      .req0       (req0),
      .req1       (req1),
      .write0     (write0),
      .write1     (write1),
      .size0      (size0),
      .size1      (size1),
      .addr0      (addr0),
      .addr1      (addr1),
      .wdata0     (wdata0),
      .wdata1     (wdata1),
      .ack0       (ack0),
      .ack1       (ack1),
      .err0       (err0),
      .err1       (err1),
      .busy0      (busy0),
      .busy1      (busy1),
      .rdata      (rdata),
      .sram_req   (sram_req),
      .sram_write (sram_write),
      .sram_size  (sram_size),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_ack   (sram_ack),
      .sram_rdata (sram_rdata)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge HCLK);
      #1;
   endtask

   task automatic do_reset();
      @(negedge HCLK);
      HRESETN = 1'b0;
      @(negedge HCLK);
      HRESETN = 1'b1;
      cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      HRESETN = 1'b0;
      req0 = 0; req1 = 0; write0 = 0; write1 = 0;
      size0 = '0; size1 = '0; addr0 = '0; addr1 = '0;
      wdata0 = '0; wdata1 = '0; sram_ack = 0; sram_rdata = '0;

      // Reset state
      #3;
      check("rst_sram_req", {31'b0, sram_req}, 32'd0);
      check("rst_acks", {28'b0, ack0, ack1, err0, err1}, 32'd0);
      check("rst_busy", {30'b0, busy0, busy1}, 32'd0);
      check("rst_cmd", {11'b0, sram_write, sram_addr}, 32'd0);
      @(negedge HCLK);
      HRESETN = 1'b1;
      cyc();

      // Single read on port 0
      req0 = 1; write0 = 0; size0 = HSIZE_WORD; addr0 = 20'h00100;      // T
      #1 check("t1_T_req", {31'b0, sram_req}, 32'd0);
      cyc(); req0 = 0;                                                   // T+1
      #1 check("t1_T1_req", {31'b0, sram_req}, 32'd0);
      cyc();                                                             // T+2
      check("t1_issue_req", {31'b0, sram_req}, 32'd1);
      check("t1_issue_addr", {12'b0, sram_addr}, 32'h00100);
      check("t1_issue_wr", {31'b0, sram_write}, 32'd0);
      check("t1_issue_size", {29'b0, sram_size}, 32'd2);
      check("t1_issue_busy", {30'b0, busy0, busy1}, 32'd1);
      cyc();                                                             // T+3
      check("t1_wait", {29'b0, sram_req, ack0, busy1}, 32'd1);
      cyc(); sram_ack = 1; sram_rdata = 32'hDEADBEEF;                    // T+4
      #1 check("t1_ack", {29'b0, ack0, err0, ack1}, 32'b100);
      check("t1_rdata", rdata, 32'hDEADBEEF);
      check("t1_ack_busy", {31'b0, busy1}, 32'd1);
      cyc(); sram_ack = 0; sram_rdata = '0; addr0 = '0; size0 = '0;      // T+5
      #1 check("t1_idle", {30'b0, busy1, ack0}, 32'd0);

      // Simultaneous requests: port 0 first, then port 1 write
      do_reset();
      req0 = 1; write0 = 0; addr0 = 20'h00300;
      req1 = 1; write1 = 1; addr1 = 20'h00200; wdata1 = 32'h12345678; size1 = HSIZE_WORD;
      cyc(); req0 = 0; req1 = 0;
      cyc();
      check("t2_first_issue", {11'b0, sram_req, sram_addr}, {11'b0, 1'b1, 20'h00300});
      check("t2_first_busy", {30'b0, busy0, busy1}, 32'd1);
      cyc();
      cyc(); sram_ack = 1;
      #1 check("t2_ack0", {30'b0, ack0, ack1}, 32'b10);
      cyc(); sram_ack = 0; addr0 = '0;
      #1 check("t2_idle_gap", {31'b0, sram_req}, 32'd0);
      cyc();
      check("t2_second_issue", {11'b0, sram_req, sram_addr}, {11'b0, 1'b1, 20'h00200});
      check("t2_second_wr", {31'b0, sram_write}, 32'd1);
      check("t2_second_wdata", sram_wdata, 32'h12345678);
      check("t2_second_busy", {30'b0, busy0, busy1}, 32'b10);
      cyc();
      check("t2_no_early_ack1", {31'b0, ack1}, 32'd0);
      cyc(); sram_ack = 1;
      #1 check("t2_ack1", {29'b0, ack0, ack1, err1}, 32'b010);
      cyc(); sram_ack = 0; write1 = 0; wdata1 = '0;

      // Fairness: both ports re-request on every ack
      addr0 = 20'h000A0; addr1 = 20'h000B0;
      req0 = 1; req1 = 1;
      cyc(); req0 = 0; req1 = 0;
      cyc();
      for (int k = 0; k < 8; k++) begin
         check($sformatf("rr%0d_issue", k), {31'b0, sram_req}, 32'd1);
         check($sformatf("rr%0d_addr", k), {12'b0, sram_addr},
               (k % 2 == 0) ? 32'h000A0 : 32'h000B0);
         cyc(); sram_ack = 1;
         if (k < 6) begin
            if (k % 2 == 0) req0 = 1; else req1 = 1;
         end
         #1 check($sformatf("rr%0d_ack", k), {30'b0, ack0, ack1},
                  (k % 2 == 0) ? 32'b10 : 32'b01);
         cyc(); sram_ack = 0; req0 = 0; req1 = 0;
         cyc();
      end
      check("rr_drained", {30'b0, busy0, busy1}, 32'd0);

      // Watchdog: port 1 never acked
      addr1 = 20'h00400;
      req1 = 1;
      cyc(); req1 = 0;
      cyc();
      check("to_issue", {11'b0, sram_req, sram_addr}, {11'b0, 1'b1, 20'h00400});
      cyc();
      check("to_wait1", {30'b0, ack1, err1}, 32'd0);
      cyc();
      cyc();
      check("to_wait3", {30'b0, ack1, err1}, 32'd0);
      cyc();
      check("to_fire", {30'b0, ack1, err1}, 32'b11);
      cyc();
      check("to_idle", {29'b0, busy0, busy1, ack1}, 32'd0);
      addr0 = 20'h00040;
      req0 = 1;
      cyc(); req0 = 0;
      cyc();
      check("to_next_issue", {11'b0, sram_req, sram_addr}, {11'b0, 1'b1, 20'h00040});
      cyc(); sram_ack = 1;
      #1 check("to_next_ack", {30'b0, ack0, err0}, 32'b10);
      cyc(); sram_ack = 0;

      // Ack in the ISSUE cycle; last=0 so port 1 wins the tie
      addr0 = 20'h00070; addr1 = 20'h00080;
      req0 = 1; req1 = 1;
      cyc(); req0 = 0; req1 = 0;
      cyc(); sram_ack = 1;
      #1 check("ia_ack1", {29'b0, sram_req, ack1, err1}, 32'b110);
      check("ia_addr", {12'b0, sram_addr}, 32'h00080);
      cyc(); sram_ack = 0;
      #1 check("ia_gap", {31'b0, sram_req}, 32'd0);
      cyc();
      check("ia_next_issue", {11'b0, sram_req, sram_addr}, {11'b0, 1'b1, 20'h00070});
      sram_ack = 1;
      #1 check("ia_ack0", {30'b0, ack0, ack1}, 32'b10);
      cyc(); sram_ack = 0; addr0 = '0;

      // Reset while port 1 is in WAIT
      addr1 = 20'h00500;
      req1 = 1;
      cyc(); req1 = 0;
      cyc();
      check("rw_issue", {31'b0, busy0}, 32'd1);
      cyc();
      HRESETN = 1'b0;
      #1 check("rw_outputs", {26'b0, ack0, ack1, err1, busy0, busy1, sram_req}, 32'd0);
      check("rw_cmd", {11'b0, sram_write, sram_addr}, 32'd0);
      @(negedge HCLK);
      HRESETN = 1'b1;
      cyc();
      for (int k = 0; k < 3; k++)
         begin
            check($sformatf("rw_quiet%0d", k), {30'b0, sram_req, busy0}, 32'd0);
            cyc();
         end
      sram_ack = 1;
      #1 check("rw_late_ack", {30'b0, ack0, ack1}, 32'd0);
      cyc(); sram_ack = 0;
      addr0 = 20'h00600;
      req0 = 1; req1 = 1;
      cyc(); req0 = 0; req1 = 0;
      cyc();
      check("rw_port0_first", {11'b0, sram_req, sram_addr}, {11'b0, 1'b1, 20'h00600});
      sram_ack = 1;
      #1 check("rw_port0_ack", {30'b0, ack0, ack1}, 32'b10);
      cyc(); sram_ack = 0;
      cyc();
      check("rw_port1_next", {11'b0, sram_req, sram_addr}, {11'b0, 1'b1, 20'h00500});
      sram_ack = 1;
      #1 check("rw_port1_ack", {30'b0, ack0, ack1}, 32'b01);
      cyc(); sram_ack = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
